// File: rtl/motor_off_timer.sv
// rtl/motor_off_timer.sv - motor auto-off countdown timer, 1 s steps, one-cycle timeout pulse
// Optional BCD remaining-seconds output enabled by MOTOR_TIMER_BCD_EN.
module motor_off_timer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TIME_W   = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [TIME_W-1:0] i_timeState,
    input  logic [2:0]        i_pwm_state,
    output logic [TIME_W-1:0] o_remain,
    output logic              o_active,
    output logic              o_timeout
`ifdef MOTOR_TIMER_BCD_EN
    ,
    output logic [7:0]        o_remain_bcd
`endif
);

    localparam int PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t            state;
    logic [TIME_W-1:0] prevTime;
    logic [PRE_W-1:0]  prescaler;
    logic              loadEvent;
    logic              tick;
    logic              pwmOn;

    assign loadEvent = (i_timeState != prevTime);
    assign tick      = (prescaler == PRE_W'(CLK_FREQ - 1));
    assign pwmOn     = (i_pwm_state != 3'd0);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            prevTime  <= '0;
            prescaler <= '0;
            o_remain  <= '0;
            o_active  <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            prevTime  <= i_timeState;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    prescaler <= '0;
                    if (loadEvent && (i_timeState != '0) && pwmOn) begin
                        state    <= RUN;
                        o_remain <= i_timeState;
                        o_active <= 1'b1;
                    end
                end
                RUN: begin
                    // Motor-off beats a new selection, which beats the 1 s tick.
                    if (!pwmOn) begin
                        state     <= IDLE;
                        o_remain  <= '0;
                        o_active  <= 1'b0;
                        prescaler <= '0;
                    end else if (loadEvent) begin
                        prescaler <= '0;
                        if (i_timeState == '0) begin
                            state    <= IDLE;
                            o_remain <= '0;
                            o_active <= 1'b0;
                        end else begin
                            o_remain <= i_timeState;
                        end
                    end else if (tick) begin
                        prescaler <= '0;
                        if (o_remain > TIME_W'(1)) begin
                            o_remain <= o_remain - TIME_W'(1);
                        end else begin
                            o_remain  <= '0;
                            state     <= EXPIRE;
                            o_active  <= 1'b0;
                            o_timeout <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + PRE_W'(1);
                    end
                end
                EXPIRE: begin
                    state     <= IDLE;
                    prescaler <= '0;
                end
                default: begin
                    state     <= IDLE;
                    prescaler <= '0;
                    o_remain  <= '0;
                    o_active  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MOTOR_TIMER_BCD_EN
    logic [TIME_W-1:0] bcdTens;
    logic [TIME_W-1:0] bcdOnes;

    assign bcdTens = o_remain / TIME_W'(10);
    assign bcdOnes = o_remain % TIME_W'(10);
    assign o_remain_bcd = {(bcdTens > TIME_W'(9)) ? 4'd9 : bcdTens[3:0], bcdOnes[3:0]};
`endif

endmodule

// File: tb/tb_motor_off_timer.sv
// tb/tb_motor_off_timer.sv - self-checking bench for motor_off_timer (CLK_FREQ=10)
module tb_motor_off_timer;

    logic       clk;
    logic       rstN;
    logic [4:0] timeState;
    logic [2:0] pwmState;
    logic [4:0] remain;
    logic       active;
    logic       timeout;
`ifdef MOTOR_TIMER_BCD_EN
    logic [7:0] remainBcd;
`endif

    motor_off_timer #(.CLK_FREQ(10), .TIME_W(5)) dut (
        .i_clk       (clk),
        .i_reset     (rstN),
        .i_timeState (timeState),
        .i_pwm_state (pwmState),
        .o_remain    (remain),
        .o_active    (active),
        .o_timeout   (timeout)
`ifdef MOTOR_TIMER_BCD_EN
        ,
        .o_remain_bcd(remainBcd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an armed timer is described by the edge it was armed at and
    // its start value; remaining time and expiry follow from elapsed edges.
    int  mEdge = 0;
    int  mArmEdge = 0;
    int  mArmVal = 0;
    int  mPrev = 0;
    int  mExpireEdge = -100;
    bit  mRun = 0;

    typedef struct {
        int ts;
        int pwm;
        int expRemain;
        int expActive;
        int expTimeout;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mRun = 0;
        mPrev = 0;
        mExpireEdge = -100;
    endtask

    task automatic modelEdge(input int ts, input int pwm);
        mEdge++;
        if (mExpireEdge == mEdge - 1) begin
            // expiry cycle: selection changes are not acted on
        end else if (mRun) begin
            if (pwm == 0) mRun = 0;
            else if (ts != mPrev) begin
                if (ts == 0) mRun = 0;
                else begin
                    mArmEdge = mEdge;
                    mArmVal = ts;
                end
            end else if (mEdge - mArmEdge == mArmVal * 10) begin
                mRun = 0;
                mExpireEdge = mEdge;
            end
        end else if (ts != mPrev && ts != 0 && pwm != 0) begin
            mRun = 1;
            mArmEdge = mEdge;
            mArmVal = ts;
        end
        mPrev = ts;
    endtask

    function automatic int modelRemain();
        return mRun ? mArmVal - (mEdge - mArmEdge) / 10 : 0;
    endfunction

    task automatic step(input int ts, input int pwm);
        int r;
        timeState = 5'(ts);
        pwmState  = 3'(pwm);
        @(posedge clk);
        modelEdge(ts, pwm);
        #1;
        r = modelRemain();
        chk("model_remain", int'(remain), r);
        chk("model_active", int'(active), int'(mRun));
        chk("model_timeout", int'(timeout), int'(mExpireEdge == mEdge));
`ifdef MOTOR_TIMER_BCD_EN
        chk("model_bcd", int'(remainBcd), ((r / 10) << 4) | (r % 10));
`endif
    endtask

    task automatic doReset();
        timeState = 5'd0;
        pwmState  = 3'd2;
        #2;
        rstN = 1'b0;
        #1;
        chk("rst_remain", int'(remain), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_timeout", int'(timeout), 0);
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic runSteps(input int n, input int ts, input int pwm);
        for (int i = 0; i < n; i++) step(ts, pwm);
    endtask

    vec_t vecs[$];

    initial begin
        rstN = 1'b1;
        timeState = 5'd0;
        pwmState = 3'd0;
        vecs = '{
            '{0,  2, 0,  0, 0},
            '{5,  0, 0,  0, 0},
            '{5,  2, 0,  0, 0},
            '{10, 2, 10, 1, 0},
            '{10, 0, 0,  0, 0},
            '{20, 1, 20, 1, 0},
            '{0,  1, 0,  0, 0},
            '{30, 3, 30, 1, 0},
            '{30, 3, 30, 1, 0}
        };
        #3;
        doReset();

        foreach (vecs[i]) begin
            step(vecs[i].ts, vecs[i].pwm);
            chk($sformatf("vec%0d_remain", i), int'(remain), vecs[i].expRemain);
            chk($sformatf("vec%0d_active", i), int'(active), vecs[i].expActive);
            chk($sformatf("vec%0d_timeout", i), int'(timeout), vecs[i].expTimeout);
        end

        // Full 10 s countdown with expiry pulse
        doReset();
        step(0, 2);
        step(10, 2);
        chk("start_remain", int'(remain), 10);
        chk("start_active", int'(active), 1);
        runSteps(99, 10, 2);
        chk("pre_expire_remain", int'(remain), 1);
        step(10, 2);
        chk("expire_timeout", int'(timeout), 1);
        chk("expire_remain", int'(remain), 0);
        chk("expire_active", int'(active), 0);
        step(10, 2);
        chk("post_expire_timeout", int'(timeout), 0);

        // Change selection mid-count restarts the prescaler
        doReset();
        step(0, 2);
        step(10, 2);
        runSteps(30, 10, 2);
        chk("change_at7", int'(remain), 7);
        step(20, 2);
        chk("change_load", int'(remain), 20);
        runSteps(9, 20, 2);
        chk("change_hold", int'(remain), 20);
        step(20, 2);
        chk("change_dec", int'(remain), 19);

        // Load and tick collide: new value wins, no decrement
        doReset();
        step(0, 2);
        step(10, 2);
        runSteps(9, 10, 2);
        step(20, 2);
        chk("collide_remain", int'(remain), 20);
        runSteps(10, 20, 2);
        chk("collide_next", int'(remain), 19);

        // Cancel by motor off, and by selection 0
        step(20, 0);
        chk("cancel_pwm_active", int'(active), 0);
        chk("cancel_pwm_remain", int'(remain), 0);
        runSteps(20, 20, 0);
        chk("cancel_pwm_no_to", int'(timeout), 0);
        step(0, 2);
        step(30, 2);
        step(0, 2);
        chk("cancel_zero_active", int'(active), 0);

        // Selection change during the expiry cycle is ignored
        doReset();
        step(0, 2);
        step(1, 2);
        runSteps(10, 1, 2);
        chk("short_expire", int'(timeout), 1);
        step(2, 2);
        chk("ignore_in_expire", int'(active), 0);
        step(2, 2);
        chk("no_rearm_same", int'(active), 0);
        step(3, 2);
        chk("rearm_new", int'(remain), 3);

        // Asynchronous reset mid-count
        doReset();
        step(0, 2);
        step(10, 2);
        runSteps(50, 10, 2);
        chk("mid_remain5", int'(remain), 5);
        timeState = 5'd0;
        #2;
        rstN = 1'b0;
        #1;
        chk("async_remain", int'(remain), 0);
        chk("async_active", int'(active), 0);
        chk("async_timeout", int'(timeout), 0);
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        runSteps(5, 0, 2);
        chk("post_rst_idle", int'(active), 0);
        step(20, 2);
        chk("post_rst_arm", int'(remain), 20);

`ifdef MOTOR_TIMER_BCD_EN
        doReset();
        step(0, 2);
        step(30, 2);
        chk("bcd_30", int'(remainBcd), 8'h30);
        step(9, 2);
        chk("bcd_09", int'(remainBcd), 8'h09);
`endif

        // Randomized stimulus against the model
        begin
            int ts;
            int pwm;
            int tsSet[7];
            tsSet = '{0, 10, 20, 30, 1, 2, 31};
            doReset();
            ts = 0;
            pwm = 2;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 39) == 0) ts = tsSet[$urandom_range(0, 6)];
                if ($urandom_range(0, 59) == 0) pwm = (pwm == 0) ? int'($urandom_range(1, 7)) : 0;
                step(ts, pwm);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
